// File: rtl/foc_cmd_pkg.sv
// foc_cmd_pkg
//   Shared definitions for the FOC command-source arbiter:
//   - arb_state_t     : arbiter state / owner encoding
//   - SRC_UDP/SRC_BUS : cmd_src encoding
//   - LOCK_CYCLES_DEF : default owner-silence timeout (100 ms at 100 MHz)
package foc_cmd_pkg;

  typedef enum logic [1:0] {
    ST_FREE    = 2'd0,
    ST_OWN_UDP = 2'd1,
    ST_OWN_BUS = 2'd2
  } arb_state_t;

  localparam logic SRC_UDP = 1'b0;
  localparam logic SRC_BUS = 1'b1;

  localparam int          LOCK_W          = 24;
  localparam logic [23:0] LOCK_CYCLES_DEF = 24'd10_000_000;

endpackage

// File: rtl/foc_cmd_arb_lock_timer.sv
// foc_cmd_arb_lock_timer
//   24-bit owner-silence counter. Clears on clr, otherwise counts while en.
//   tc flags that the count has reached LOCK_CYCLES-1.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   clr        : clear counter (has priority over en)
//   en         : count enable
//   tc         : terminal count reached
module foc_cmd_arb_lock_timer
  import foc_cmd_pkg::*;
#(
  parameter logic [23:0] LOCK_CYCLES = LOCK_CYCLES_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic tc
);

  logic [LOCK_W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= cnt + 24'd1;
    end
  end

  assign tc = (cnt == (LOCK_CYCLES - 24'd1));

endmodule

// File: rtl/foc_cmd_arb.sv
// foc_cmd_arb
//   Grants exclusive command ownership to either the UDP host or the serial
//   bus and forwards only the owner's commands as one registered strobe.
//   Ownership is dropped after LOCK_CYCLES of owner silence or on release_req.
// Ports:
//   c, rst_n                       : clock, asynchronous active-low reset
//   udp_cmd_dv/target/damping      : UDP command strobe and payload
//   bus_cmd_dv/target/damping/
//   bus_control_id                 : bus command strobe and payload
//   release_req                    : force ownership free (level, per cycle)
//   cmd_dv                         : one-cycle accepted-command strobe
//   cmd_target/damping/control_id  : last accepted payload (control id 0 for UDP)
//   cmd_src                        : source of last accept (0 udp, 1 bus)
//   owner                          : 00 free, 01 udp, 10 bus
//   drop_cnt                       : saturating rejected-command count
// Configuration:
//   FOC_CMD_ARB_STATS_EN : when defined, drop_cnt counts drops; otherwise 0.
module foc_cmd_arb
  import foc_cmd_pkg::*;
#(
  parameter logic [23:0] LOCK_CYCLES = LOCK_CYCLES_DEF,
  parameter logic        BUS_PRIO    = 1'b1
) (
  input  logic        c,
  input  logic        rst_n,
  input  logic        udp_cmd_dv,
  input  logic [31:0] udp_target,
  input  logic [31:0] udp_damping,
  input  logic        bus_cmd_dv,
  input  logic [31:0] bus_target,
  input  logic [31:0] bus_damping,
  input  logic [31:0] bus_control_id,
  input  logic        release_req,
  output logic        cmd_dv,
  output logic [31:0] cmd_target,
  output logic [31:0] cmd_damping,
  output logic [31:0] cmd_control_id,
  output logic        cmd_src,
  output logic [1:0]  owner,
  output logic [15:0] drop_cnt
);

  arb_state_t state, eff_state, next_state;
  logic       acc_udp, acc_bus, accept;
  logic       lock_tc;

  // A release in the same cycle makes the strobes arbitrate as if free.
  always_comb begin
    eff_state = release_req ? ST_FREE : state;
    acc_udp   = 1'b0;
    acc_bus   = 1'b0;
    case (eff_state)
      ST_FREE: begin
        if (udp_cmd_dv && bus_cmd_dv) begin
          acc_bus = BUS_PRIO;
          acc_udp = ~BUS_PRIO;
        end else begin
          acc_udp = udp_cmd_dv;
          acc_bus = bus_cmd_dv;
        end
      end
      ST_OWN_UDP: acc_udp = udp_cmd_dv;
      ST_OWN_BUS: acc_bus = bus_cmd_dv;
      default: ;
    endcase
    accept = acc_udp | acc_bus;

    // An owner strobe beats a coinciding timeout.
    if (acc_bus)                            next_state = ST_OWN_BUS;
    else if (acc_udp)                       next_state = ST_OWN_UDP;
    else if (release_req)                   next_state = ST_FREE;
    else if (state != ST_FREE && lock_tc)   next_state = ST_FREE;
    else                                    next_state = state;
  end

  // Every accept either enters or refreshes ownership, so it clears the timer.
  foc_cmd_arb_lock_timer #(
    .LOCK_CYCLES (LOCK_CYCLES)
  ) u_lock_timer (
    .clk   (c),
    .rst_n (rst_n),
    .clr   (accept),
    .en    (state != ST_FREE),
    .tc    (lock_tc)
  );

  // ---- stage p1: registered state and accepted command ----
  always_ff @(posedge c or negedge rst_n) begin
    if (!rst_n) begin
      state          <= ST_FREE;
      cmd_dv         <= 1'b0;
      cmd_target     <= '0;
      cmd_damping    <= '0;
      cmd_control_id <= '0;
      cmd_src        <= SRC_UDP;
    end else begin
      state  <= next_state;
      cmd_dv <= accept;
      if (acc_bus) begin
        cmd_target     <= bus_target;
        cmd_damping    <= bus_damping;
        cmd_control_id <= bus_control_id;
        cmd_src        <= SRC_BUS;
      end else if (acc_udp) begin
        cmd_target     <= udp_target;
        cmd_damping    <= udp_damping;
        cmd_control_id <= '0;
        cmd_src        <= SRC_UDP;
      end
    end
  end

  assign owner = state;

`ifdef FOC_CMD_ARB_STATS_EN
  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // At most one strobe can lose arbitration in a cycle.
  logic drop;
  assign drop = (udp_cmd_dv & ~acc_udp) | (bus_cmd_dv & ~acc_bus);

  always_ff @(posedge c or negedge rst_n) begin
    if (!rst_n) begin
      drop_cnt <= '0;
    end else if (drop) begin
      drop_cnt <= sat_inc16(drop_cnt);
    end
  end
`else
  assign drop_cnt = 16'h0;
`endif

endmodule

// File: tb/tb_foc_cmd_arb.sv
// tb_foc_cmd_arb
//   Scoreboard bench for foc_cmd_arb. Two instances share the stimulus:
//   dut_a with BUS_PRIO=1, dut_b with BUS_PRIO=0, both with LOCK_CYCLES=100.
//   Expected outputs come from a behavioural model, are queued when the
//   stimulus is driven and compared one clock later.
module tb_foc_cmd_arb;

  localparam int LOCK = 100;

  typedef struct packed {
    logic [1:0]  owner;
    logic [31:0] silent;
    logic        dv;
    logic [31:0] tgt;
    logic [31:0] dmp;
    logic [31:0] cid;
    logic        src;
    logic [15:0] drop;
  } mdl_t;

  typedef struct packed {
    mdl_t a;
    mdl_t b;
  } exp_t;

  logic        c = 1'b0;
  logic        rst_n;
  logic        udp_cmd_dv, bus_cmd_dv, release_req;
  logic [31:0] udp_target, udp_damping, bus_target, bus_damping, bus_control_id;

  logic        a_dv, b_dv, a_src, b_src;
  logic [31:0] a_tgt, a_dmp, a_cid, b_tgt, b_dmp, b_cid;
  logic [1:0]  a_own, b_own;
  logic [15:0] a_drop, b_drop;

  int   checks   = 0;
  int   failures = 0;
  mdl_t ma, mb;
  exp_t exp_q[$];

  always #5 c = ~c;

  foc_cmd_arb #(.LOCK_CYCLES(24'd100), .BUS_PRIO(1'b1)) dut_a (
    .c(c), .rst_n(rst_n),
    .udp_cmd_dv(udp_cmd_dv), .udp_target(udp_target), .udp_damping(udp_damping),
    .bus_cmd_dv(bus_cmd_dv), .bus_target(bus_target), .bus_damping(bus_damping),
    .bus_control_id(bus_control_id), .release_req(release_req),
    .cmd_dv(a_dv), .cmd_target(a_tgt), .cmd_damping(a_dmp),
    .cmd_control_id(a_cid), .cmd_src(a_src), .owner(a_own), .drop_cnt(a_drop)
  );

  foc_cmd_arb #(.LOCK_CYCLES(24'd100), .BUS_PRIO(1'b0)) dut_b (
    .c(c), .rst_n(rst_n),
    .udp_cmd_dv(udp_cmd_dv), .udp_target(udp_target), .udp_damping(udp_damping),
    .bus_cmd_dv(bus_cmd_dv), .bus_target(bus_target), .bus_damping(bus_damping),
    .bus_control_id(bus_control_id), .release_req(release_req),
    .cmd_dv(b_dv), .cmd_target(b_tgt), .cmd_damping(b_dmp),
    .cmd_control_id(b_cid), .cmd_src(b_src), .owner(b_own), .drop_cnt(b_drop)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic cmp(input string p, input mdl_t e, input logic dv,
                     input logic [31:0] tg, input logic [31:0] dm, input logic [31:0] id,
                     input logic src, input logic [1:0] own, input logic [15:0] dc);
    chk({p, ".cmd_dv"},   32'(dv),  32'(e.dv));
    chk({p, ".target"},   tg,       e.tgt);
    chk({p, ".damping"},  dm,       e.dmp);
    chk({p, ".ctrl_id"},  id,       e.cid);
    chk({p, ".cmd_src"},  32'(src), 32'(e.src));
    chk({p, ".owner"},    32'(own), 32'(e.owner));
    chk({p, ".drop_cnt"}, 32'(dc),  32'(e.drop));
  endtask

  task automatic cmp_both(input string p, input mdl_t ea, input mdl_t eb);
    cmp({p, "/a"}, ea, a_dv, a_tgt, a_dmp, a_cid, a_src, a_own, a_drop);
    cmp({p, "/b"}, eb, b_dv, b_tgt, b_dmp, b_cid, b_src, b_own, b_drop);
  endtask

  // Behavioural reference: owner 0 free / 1 udp / 2 bus, silent = idle cycles owned.
  function automatic mdl_t step(input mdl_t m, input logic prio,
                                input logic u, input logic [31:0] ut, input logic [31:0] ud,
                                input logic b, input logic [31:0] bt, input logic [31:0] bd,
                                input logic [31:0] bid, input logic rel);
    mdl_t n;
    logic [1:0] who;
    logic tu, tb;
    n = m;
    n.dv = 1'b0;
    tu = 1'b0;
    tb = 1'b0;
    who = rel ? 2'd0 : m.owner;
    case (who)
      2'd0: begin
        if (b && (prio || !u)) tb = 1'b1;
        else if (u)            tu = 1'b1;
      end
      2'd1:    tu = u;
      default: tb = b;
    endcase
    if (tu) begin
      n.owner = 2'd1; n.dv = 1'b1; n.tgt = ut; n.dmp = ud; n.cid = 32'd0;
      n.src = 1'b0; n.silent = 32'd0;
    end else if (tb) begin
      n.owner = 2'd2; n.dv = 1'b1; n.tgt = bt; n.dmp = bd; n.cid = bid;
      n.src = 1'b1; n.silent = 32'd0;
    end else if (rel) begin
      n.owner = 2'd0;
    end else if (m.owner != 2'd0) begin
      if (m.silent == 32'(LOCK - 1)) n.owner = 2'd0;
      else                           n.silent = m.silent + 32'd1;
    end
`ifdef FOC_CMD_ARB_STATS_EN
    if ((u && !tu) || (b && !tb))
      n.drop = (m.drop == 16'hFFFF) ? m.drop : m.drop + 16'd1;
`endif
    return n;
  endfunction

  // One clock of stimulus; expectation queued now, checked after the edge.
  task automatic cyc(input logic u, input logic [31:0] ut, input logic [31:0] ud,
                     input logic b, input logic [31:0] bt, input logic [31:0] bd,
                     input logic [31:0] bid, input logic rel);
    exp_t e;
    @(negedge c);
    udp_cmd_dv = u; udp_target = ut; udp_damping = ud;
    bus_cmd_dv = b; bus_target = bt; bus_damping = bd; bus_control_id = bid;
    release_req = rel;
    ma = step(ma, 1'b1, u, ut, ud, b, bt, bd, bid, rel);
    mb = step(mb, 1'b0, u, ut, ud, b, bt, bd, bid, rel);
    e.a = ma;
    e.b = mb;
    exp_q.push_back(e);
    @(posedge c);
    #1;
    e = exp_q.pop_front();
    cmp_both("cyc", e.a, e.b);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    rst_n = 1'b0;
    udp_cmd_dv = 0; bus_cmd_dv = 0; release_req = 0;
    udp_target = 0; udp_damping = 0; bus_target = 0; bus_damping = 0; bus_control_id = 0;
    ma = '0;
    mb = '0;
    repeat (2) @(posedge c);
    #1;
    cmp_both("reset", '0, '0);
    @(negedge c);
    rst_n = 1'b1;

    // UDP takes ownership from free, then hold/timeout around LOCK cycles.
    cyc(1, 32'h3f80_0000, 32'h3e00_0000, 0, 0, 0, 0, 0);
    idle(LOCK - 1);
    cyc(1, 32'h4000_0000, 32'h3f00_0000, 0, 0, 0, 0, 0);
    idle(LOCK + 2);

    // Simultaneous strobes while free: priority source wins, other dropped.
    cyc(1, 32'h1111_1111, 32'h2222_2222, 1, 32'h3333_3333, 32'h4444_4444, 32'd3, 0);
    // Five non-owner strobes against the bus owner (dut_a), then a bus command.
    for (int i = 0; i < 5; i++)
      cyc(1, 32'hA000_0000 + 32'(i), 32'hB000_0000, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 1, 32'h4120_0000, 32'h3dcc_cccd, 32'd7, 0);
    idle(2);

    // Release alone, UDP regains ownership, then release with a bus strobe.
    cyc(0, 0, 0, 0, 0, 0, 0, 1);
    cyc(1, 32'h3fc0_0000, 32'h3e80_0000, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 1, 32'hc000_0000, 32'h3f40_0000, 32'd9, 1);
    idle(1);

    // Three accepts, then asynchronous reset mid-ownership.
    for (int i = 0; i < 3; i++)
      cyc(0, 0, 0, 1, 32'h5000_0000 + 32'(i), 32'h6000_0000, 32'(20 + i), 0);
    @(negedge c);
    rst_n = 1'b0;
    udp_cmd_dv = 0; bus_cmd_dv = 0; release_req = 0;
    #1;
    ma = '0;
    mb = '0;
    exp_q.delete();
    cmp_both("async_rst", '0, '0);
    @(negedge c);
    rst_n = 1'b1;
    cyc(1, 32'h3f80_0000, 32'h3f80_0000, 0, 0, 0, 0, 0);
    idle(1);

    // Mixed random traffic.
    for (int i = 0; i < 400; i++)
      cyc($urandom_range(0, 3) == 0, $urandom, $urandom,
          $urandom_range(0, 3) == 0, $urandom, $urandom, $urandom,
          $urandom_range(0, 24) == 0);
    idle(LOCK + 2);

    chk("sb_empty", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
